regfile_write_arbiter: RTL
==========================

Name: regfile_write_arbiter

Overview:
- Sequences the single write port of the 32x32 register file between two writeback requesters: A (ALU result) and B (load data).
- Arbitrates with valid/ready handshakes and presents a registered write to the register file.
- Keeps a per-register busy scoreboard so decode can stall on read-after-write hazards.
- Sits between the execute/load writeback paths and the register file write inputs.

Parameters:
- DATA_W, 32, write data width
- ADDR_W, 5, register address width
- NREG, 32, number of architectural registers (2**ADDR_W)
- FIXED_PRIO, 0, 0 = round-robin between A and B; 1 = A always wins

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- a_valid  input  1  requester A has a write
- a_ready  output  1  A granted this cycle
- a_addr  input  ADDR_W  A destination register
- a_data  input  DATA_W  A write data
- b_valid  input  1  requester B has a write
- b_ready  output  1  B granted this cycle
- b_addr  input  ADDR_W  B destination register
- b_data  input  DATA_W  B write data
- rf_we  output  1  register file write enable (registered)
- rf_waddr  output  ADDR_W  register file write address (registered)
- rf_wdata  output  DATA_W  register file write data (registered)
- issue_valid  input  1  decode issues an instruction writing issue_rd
- issue_rd  input  ADDR_W  destination of the issued instruction
- rs1_addr  input  ADDR_W  decode source 1
- rs2_addr  input  ADDR_W  decode source 2
- rs1_busy  output  1  rs1 has a pending write (combinational from busy bits)
- rs2_busy  output  1  rs2 has a pending write (combinational)
- pending_cnt  output  ADDR_W+1  number of busy registers (registered)

Behaviour:
- Reset (reset=0, async): busy[*]=0; rf_we=0; rf_waddr=0; rf_wdata=0; pending_cnt=0; last_grant=B, so A wins the first contest. Any in-flight transfer is discarded.
- Grant logic is combinational in cycle T. ready is only asserted for a valid requester; at most one of a_ready/b_ready is high.
  - Only one requester valid: it is granted.
  - Both valid, FIXED_PRIO=0: grant the requester not in last_grant.
  - Both valid, FIXED_PRIO=1: grant A.
- A transfer occurs when valid && ready. last_grant updates only on a transfer. The ungranted requester must hold valid/addr/data stable.
- Write latency is 1. At the edge ending T, rf_we <= (transfer && addr!=0), and rf_waddr/rf_wdata <= the granted addr/data.
  - No transfer: rf_we <= 0; addr and data hold.
  - Writes to x0 are consumed (ready high) but never produce rf_we.
- Scoreboard:
  - busy[r] is set at the edge ending a cycle with issue_valid && issue_rd==r && r!=0.
  - busy[r] is cleared at the edge ending the cycle in which rf_we=1 && rf_waddr==r. This is the same edge on which the register file stores the data.
  - Set and clear of the same register on the same edge: set wins, busy stays 1.
  - busy[0] is always 0.
  - Issue to a register that is already busy: it stays busy (single bit, no count). Upstream must not issue a second writer of a busy register.
- rsN_busy = busy[rsN_addr] (0 for x0). There is no bypass from rf_wdata.
- pending_cnt <= pending_cnt + (effective set of a not-busy register) - (effective clear). It always equals the popcount of busy and never exceeds NREG-1.
- Back-to-back transfers are allowed every cycle. Throughput is one write per cycle.

Test Plan:
- Reset release, a_valid=1 a_addr=5 a_data=0xDEADBEEF -> a_ready=1 in T; at T+1 rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF; at T+2 rf_we=0.
- a_valid=b_valid=1 held for 4 cycles, FIXED_PRIO=0, addrs 3/4 -> grants A,B,A,B; rf_waddr sequence 3,4,3,4 with no idle cycle. With FIXED_PRIO=1 -> A every cycle, b_ready=0.
- b_valid=1 b_addr=0 b_data=0x1234 -> b_ready=1, rf_we stays 0; issue_rd=0 -> rs1_busy=0 for rs1_addr=0, pending_cnt=0.
- issue_valid issue_rd=7, then rs1_addr=7 -> rs1_busy=1, pending_cnt=1; A writes r7 -> rs1_busy falls at the edge after rf_we=1, pending_cnt=0.
- issue_rd=9 in the same cycle that rf_we=1 rf_waddr=9 -> busy[9] remains 1, pending_cnt unchanged.
- Drive reset=0 mid-stream, between clk edges, with busy[7]=1 and a transfer in flight -> rf_we=0, rs1_busy=0, pending_cnt=0 immediately. The first contested grant after release goes to A.

Source files
------------

// File: rtl/regfile_write_arbiter_if.sv
// regfile_write_arbiter_if: writeback requesters, register-file write port and hazard scoreboard signals
interface regfile_write_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              a_valid;
    logic              a_ready;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_data;
    logic              b_valid;
    logic              b_ready;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_data;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic              issue_valid;
    logic [ADDR_W-1:0] issue_rd;
    logic [ADDR_W-1:0] rs1_addr;
    logic [ADDR_W-1:0] rs2_addr;
    logic              rs1_busy;
    logic              rs2_busy;
    logic [ADDR_W:0]   pending_cnt;

    modport master (
        output a_valid, a_addr, a_data, b_valid, b_addr, b_data,
        output issue_valid, issue_rd, rs1_addr, rs2_addr,
        input  a_ready, b_ready, rf_we, rf_waddr, rf_wdata,
        input  rs1_busy, rs2_busy, pending_cnt
    );

    modport slave (
        input  a_valid, a_addr, a_data, b_valid, b_addr, b_data,
        input  issue_valid, issue_rd, rs1_addr, rs2_addr,
        output a_ready, b_ready, rf_we, rf_waddr, rf_wdata,
        output rs1_busy, rs2_busy, pending_cnt
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: arbitrates two writeback sources onto one register-file write port and tracks busy registers
module regfile_write_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int NREG       = 32,
    parameter bit FIXED_PRIO = 1'b0
) (
    input logic                    clk_i,
    input logic                    reset_ni,
    regfile_write_arbiter_if.slave bus
);
    localparam logic [NREG-1:0] ONE = NREG'(1);

    typedef enum logic {GNT_A, GNT_B} grant_e;

    grant_e            last_q, last_d;
    logic              grant_a, grant_b, xfer;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;
    logic              rf_we_q, rf_we_d;
    logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
    logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
    logic [NREG-1:0]   busy_q, busy_d, set_vec, clr_vec;
    logic              set_eff, clr_eff;
    logic [ADDR_W:0]   pending_q, pending_d;

    // Grant: a lone requester always wins; on contention A wins unless round-robin says B is due
    always_comb begin
        grant_a  = bus.a_valid && (!bus.b_valid || FIXED_PRIO || last_q == GNT_B);
        grant_b  = bus.b_valid && !grant_a;
        xfer     = grant_a || grant_b;
        sel_addr = grant_a ? bus.a_addr : bus.b_addr;
        sel_data = grant_a ? bus.a_data : bus.b_data;
        last_d   = grant_a ? GNT_A : grant_b ? GNT_B : last_q;
    end

    // Write stage: x0 writes are accepted but never reach the register file; idle cycles hold address/data
    always_comb begin
        rf_we_d    = xfer && sel_addr != '0;
        rf_waddr_d = xfer ? sel_addr : rf_waddr_q;
        rf_wdata_d = xfer ? sel_data : rf_wdata_q;
    end

    // Scoreboard: clear on the edge the register file stores the data, set on issue; set overrides clear
    always_comb begin
        set_vec   = (bus.issue_valid && bus.issue_rd != '0) ? ONE << bus.issue_rd : '0;
        clr_vec   = rf_we_q ? ONE << rf_waddr_q : '0;
        busy_d    = ((busy_q & ~clr_vec) | set_vec) & ~ONE;
        set_eff   = |(set_vec & ~busy_q);
        clr_eff   = |(clr_vec & busy_q & ~set_vec);
        pending_d = pending_q + {{ADDR_W{1'b0}}, set_eff} - {{ADDR_W{1'b0}}, clr_eff};
    end

    // State registers; reset drops any in-flight write and forgets all pending writers
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            last_q     <= GNT_B;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            busy_q     <= '0;
            pending_q  <= '0;
        end else begin
            last_q     <= last_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            busy_q     <= busy_d;
            pending_q  <= pending_d;
        end
    end

    assign bus.a_ready     = grant_a;
    assign bus.b_ready     = grant_b;
    assign bus.rf_we       = rf_we_q;
    assign bus.rf_waddr    = rf_waddr_q;
    assign bus.rf_wdata    = rf_wdata_q;
    assign bus.rs1_busy    = busy_q[bus.rs1_addr];
    assign bus.rs2_busy    = busy_q[bus.rs2_addr];
    assign bus.pending_cnt = pending_q;
endmodule
